// File: rtl/memory_tester.sv
// ============================================================================
// Module      : memory_tester
// Description : Load bytes into a source memory, stream them through an
//               internal synchronous FIFO into a destination memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_tester #(
  parameter int DATA_W     = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] port_A,
  input  logic              W_en,
  input  logic              s_sig,
  input  logic              R_en,
  output logic [DATA_W-1:0] port_D,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              done
);

  localparam int c_ADDR_W = $clog2(MEM_DEPTH);
  localparam int c_IDX_W  = c_ADDR_W + 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [c_IDX_W-1:0] c_MEM_END = c_IDX_W'(MEM_DEPTH);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  logic [DATA_W-1:0]  Feature_Memory [MEM_DEPTH];
  logic [DATA_W-1:0]  Weight_Memory  [MEM_DEPTH];
  logic [DATA_W-1:0]  r_fifo         [FIFO_DEPTH];

  logic [c_IDX_W-1:0] r_wr_cnt;
  logic [c_IDX_W-1:0] r_src_idx;
  logic [c_IDX_W-1:0] r_dst_idx;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [DATA_W-1:0]  r_port_d;
  logic               r_done;

  logic               w_empty;
  logic               w_full;
  logic               w_load;
  logic               w_push;
  logic               w_pop;
  logic [DATA_W-1:0]  w_fifo_head;

  // Extra pointer MSB distinguishes a full buffer from an empty one
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_PTR_W-1] != r_rptr[c_PTR_W-1]) &&
                   (r_wptr[c_PTR_W-2:0] == r_rptr[c_PTR_W-2:0]);

  assign w_load      = W_en && (r_wr_cnt < c_MEM_END);
  assign w_push      = s_sig && !w_full && (r_src_idx < r_wr_cnt);
  assign w_pop       = R_en && !w_empty && (r_dst_idx < c_MEM_END);
  assign w_fifo_head = r_fifo[r_rptr[c_PTR_W-2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_src_idx <= '0;
      r_dst_idx <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_port_d  <= '0;
      r_done    <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        Feature_Memory[i] <= '0;
        Weight_Memory[i]  <= '0;
      end
    end else begin
      if (w_load) begin
        Feature_Memory[r_wr_cnt[c_ADDR_W-1:0]] <= port_A;
        r_wr_cnt <= r_wr_cnt + c_IDX_ONE;
      end
      if (w_push) begin
        r_src_idx <= r_src_idx + c_IDX_ONE;
        r_wptr    <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        Weight_Memory[r_dst_idx[c_ADDR_W-1:0]] <= w_fifo_head;
        r_port_d  <= w_fifo_head;
        r_dst_idx <= r_dst_idx + c_IDX_ONE;
        r_rptr    <= r_rptr + c_PTR_ONE;
        if (r_dst_idx == c_MEM_END - c_IDX_ONE)
          r_done <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: pointers alone decide which slots are valid
  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wptr[c_PTR_W-2:0]] <= Feature_Memory[r_src_idx[c_ADDR_W-1:0]];
  end

  assign port_D     = r_port_d;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_memory_tester.sv
// ============================================================================
// Module      : tb_memory_tester
// Description : Self-checking bench for memory_tester with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] port_A = '0;
  logic       W_en = 1'b0;
  logic       s_sig = 1'b0;
  logic       R_en = 1'b0;
  logic [7:0] port_D;
  logic       fifo_full;
  logic       fifo_empty;
  logic       done;

  memory_tester dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_A    (port_A),
    .W_en      (W_en),
    .s_sig     (s_sig),
    .R_en      (R_en),
    .port_D    (port_D),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] seq [16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                           8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};

  // Model: source array + load count, FIFO as a queue, destination array + count
  logic [7:0] m_fm [16];
  logic [7:0] m_wm [16];
  logic [7:0] m_q [$];
  int         m_ld, m_sent, m_wn;
  logic [7:0] m_pd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_fm[i] = '0;
      m_wm[i] = '0;
    end
    m_q.delete();
    m_ld = 0; m_sent = 0; m_wn = 0; m_pd = '0;
  endtask

  task automatic model_step();
    bit do_pop, do_push, do_load;
    do_pop  = R_en && (m_q.size() > 0) && (m_wn < 16);
    do_push = s_sig && (m_q.size() < 8) && (m_sent < m_ld);
    do_load = W_en && (m_ld < 16);
    if (do_pop) begin
      m_pd = m_q.pop_front();
      m_wm[m_wn] = m_pd;
      m_wn++;
    end
    if (do_push) begin
      m_q.push_back(m_fm[m_sent]);
      m_sent++;
    end
    if (do_load) begin
      m_fm[m_ld] = port_A;
      m_ld++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("port_D",     32'(port_D),     32'(m_pd));
      chk("fifo_full",  32'(fifo_full),  32'(m_q.size() == 8));
      chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
      chk("done",       32'(done),       32'(m_wn == 16));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic mem_vs_model(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_feature"}, 32'(dut.Feature_Memory[i]), 32'(m_fm[i]));
      chk({tag, "_weight"},  32'(dut.Weight_Memory[i]),  32'(m_wm[i]));
    end
  endtask

  // Reset pulse placed entirely between clock edges; outputs checked while asserted
  task automatic do_reset(input string tag);
    W_en = 1'b0; s_sig = 1'b0; R_en = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_port_D"}, 32'(port_D), 32'd0);
    chk({tag, "_rst_empty"},  32'(fifo_empty), 32'd1);
    chk({tag, "_rst_full"},   32'(fifo_full), 32'd0);
    chk({tag, "_rst_done"},   32'(done), 32'd0);
    mem_vs_model({tag, "_rst"});
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      port_A = seq[i % 16];
      W_en = 1'b1;
      tick(1);
    end
    W_en = 1'b0;
  endtask

  initial begin
    // 1. Full run
    do_reset("t1");
    load(16);
    s_sig = 1'b1; R_en = 1'b1;
    tick(40);
    s_sig = 1'b0; R_en = 1'b0;
    for (int i = 0; i < 16; i++) chk("t1_weight_lit", 32'(dut.Weight_Memory[i]), 32'(seq[i]));
    chk("t1_port_D_lit", 32'(port_D), 32'd95);
    chk("t1_done_lit", 32'(done), 32'd1);
    chk("t1_empty_lit", 32'(fifo_empty), 32'd1);
    mem_vs_model("t1");
    // Further enables after completion change nothing
    s_sig = 1'b1; R_en = 1'b1;
    tick(4);
    s_sig = 1'b0; R_en = 1'b0;
    chk("t1_rearm_port_D", 32'(port_D), 32'd95);

    // 2. Backpressure
    do_reset("t2");
    load(16);
    s_sig = 1'b1;
    tick(7);
    chk("t2_full_after7", 32'(fifo_full), 32'd0);
    tick(1);
    chk("t2_full_after8", 32'(fifo_full), 32'd1);
    tick(12);
    chk("t2_port_D_lit", 32'(port_D), 32'd0);
    for (int i = 0; i < 16; i++) chk("t2_weight_zero", 32'(dut.Weight_Memory[i]), 32'd0);
    R_en = 1'b1;
    tick(30);
    s_sig = 1'b0; R_en = 1'b0;
    for (int i = 0; i < 16; i++) chk("t2_weight_lit", 32'(dut.Weight_Memory[i]), 32'(seq[i]));
    chk("t2_done_lit", 32'(done), 32'd1);

    // 3a. Overflow: 17th write ignored
    do_reset("t3a");
    load(16);
    port_A = 8'hEE; W_en = 1'b1;
    tick(1);
    W_en = 1'b0;
    chk("t3_feature0_lit", 32'(dut.Feature_Memory[0]), 32'd4);
    chk("t3_feature15_lit", 32'(dut.Feature_Memory[15]), 32'd95);
    mem_vs_model("t3a");

    // 3b. Partial load of 5 bytes
    do_reset("t3b");
    load(5);
    s_sig = 1'b1; R_en = 1'b1;
    tick(30);
    s_sig = 1'b0; R_en = 1'b0;
    for (int i = 0; i < 16; i++)
      chk("t3_partial_lit", 32'(dut.Weight_Memory[i]), (i < 5) ? 32'(seq[i]) : 32'd0);
    chk("t3_partial_done", 32'(done), 32'd0);
    chk("t3_partial_port_D", 32'(port_D), 32'd141);

    // 4. Drain with nothing pushed
    do_reset("t4");
    load(16);
    R_en = 1'b1;
    tick(10);
    R_en = 1'b0;
    chk("t4_port_D_lit", 32'(port_D), 32'd0);
    chk("t4_empty_lit", 32'(fifo_empty), 32'd1);
    mem_vs_model("t4");

    // 5. Reset after 6 pops (first pop lands one edge after the first push)
    do_reset("t5a");
    load(16);
    s_sig = 1'b1; R_en = 1'b1;
    tick(7);
    chk("t5_pops_lit", 32'(dut.Weight_Memory[5]), 32'd243);
    chk("t5_pop6_only", 32'(dut.Weight_Memory[6]), 32'd0);
    do_reset("t5");

    // 6. Concurrent load and transfer
    begin
      bit seen_done = 1'b0;
      do_reset("t6");
      for (int c = 0; c < 20; c++) begin
        if (c < 16) begin
          port_A = seq[c]; W_en = 1'b1;
        end else begin
          W_en = 1'b0;
        end
        s_sig = 1'b1; R_en = 1'b1;
        tick(1);
        if (done) begin
          seen_done = 1'b1;
          break;
        end
      end
      W_en = 1'b0; s_sig = 1'b0; R_en = 1'b0;
      chk("t6_done_within_20", 32'(seen_done), 32'd1);
      for (int i = 0; i < 16; i++) chk("t6_weight_lit", 32'(dut.Weight_Memory[i]), 32'(seq[i]));
      mem_vs_model("t6");
    end

    tick(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_tester.md
Name: memory_tester

Overview:
- Self-contained memory-to-memory transfer block used for FIFO bring-up.
- Bytes are written over port_A into a 16-entry source memory (Feature_Memory).
- They are then streamed through an internal synchronous FIFO into a 16-entry destination memory (Weight_Memory).
- The most recently transferred byte is presented on port_D. Everything runs on a single clock domain.

Parameters:
- DATA_W, 8, data width of port_A, port_D, memories and FIFO.
- MEM_DEPTH, 16, entries in Feature_Memory and Weight_Memory (power of two).
- FIFO_DEPTH, 8, entries in the internal FIFO (power of two, ≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- port_A  input  DATA_W  load data for Feature_Memory.
- W_en  input  1  load strobe; one byte accepted per clk while high.
- s_sig  input  1  transfer enable; pushes Feature_Memory contents into FIFO.
- R_en  input  1  drain enable; pops FIFO into Weight_Memory.
- port_D  output  DATA_W  last byte popped from FIFO.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  output  1  FIFO holds 0 entries.
- done  output  1  Weight_Memory fully written (MEM_DEPTH pops).

Behaviour:
- Reset (rst_n low, async):
  - Indices wr_cnt, src_idx and dst_idx cleared.
  - FIFO pointers cleared; fifo_empty=1, fifo_full=0.
  - port_D=0, done=0.
  - Both memories cleared to 0.
  - Reset mid-operation aborts all phases immediately.
- Memories:
  - Arrays are named Feature_Memory and Weight_Memory, indexed [0..MEM_DEPTH-1].
  - Both must be hierarchically accessible to benches.
- Load:
  - On each edge with W_en=1 and wr_cnt<MEM_DEPTH: Feature_Memory[wr_cnt]<=port_A, then wr_cnt++.
  - Writes when wr_cnt==MEM_DEPTH are ignored (no wrap).
- Push:
  - On each edge with s_sig=1, !fifo_full and src_idx<wr_cnt: FIFO[wptr]<=Feature_Memory[src_idx], then src_idx++ and wptr++.
  - Only loaded entries are ever pushed. A byte loaded on edge N is pushable from edge N+1.
- Pop:
  - On each edge with R_en=1, !fifo_empty and dst_idx<MEM_DEPTH:
    - Weight_Memory[dst_idx]<=FIFO[rptr];
    - port_D<=FIFO[rptr];
    - dst_idx++, rptr++.
  - Otherwise port_D holds its value.
- FIFO:
  - Circular buffer with pointers one bit wider than log2(FIFO_DEPTH).
  - Empty when pointers are equal. Full when the low bits are equal and the MSB differs.
  - Flags are registered-consistent (derived from current pointers) and valid in the same cycle.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Push gating uses the current full flag, pop gating the current empty flag; no bypass.
- Latency:
  - A byte pushed on edge N can be popped on edge N+1 at the earliest.
  - With s_sig=R_en=1 throughout, throughput is 1 byte/cycle; all 16 bytes land by 17 edges.
- done:
  - Goes 1 on the edge where dst_idx reaches MEM_DEPTH and stays 1 until reset.
- Simultaneous W_en and s_sig:
  - Legal. A transfer may trail loading by ≥1 cycle.
- Order:
  - Weight_Memory[i] equals Feature_Memory[i] for every transferred i.
  - No reordering, loss or duplication.
- Restart:
  - No re-arm without reset; further s_sig/R_en after completion has no effect.

Test Plan:
1. Full run:
   - Stimulus: reset, then load 4,14,24,42,141,243,41,134,204,124,104,24,34,74,84,95 with W_en. Then W_en=0 and s_sig=R_en=1 for 40 cycles.
   - Required: Weight_Memory[0..15] equals that sequence, port_D=95, done=1, fifo_empty=1.
2. Backpressure:
   - Stimulus: after the full load, s_sig=1 with R_en=0 for 20 cycles.
   - Required: fifo_full=1 after exactly 8 pushes (src_idx=8), port_D=0, Weight_Memory all 0.
   - Stimulus: then R_en=1.
   - Required: the remaining transfer completes in order and done=1.
3. Overflow/partial load:
   - Stimulus: 17 writes.
   - Required: the 17th is ignored and Feature_Memory[0] is unchanged.
   - Stimulus: separately, load only 5 bytes and transfer.
   - Required: exactly 5 land in Weight_Memory[0..4], [5..15]=0, done=0.
4. Empty drain:
   - Stimulus: R_en=1 with s_sig=0 after load.
   - Required: port_D stays 0, fifo_empty stays 1, no Weight_Memory writes.
5. Reset mid-transfer:
   - Stimulus: drop rst_n after 6 pops.
   - Required: port_D=0, both memories 0 and flags at reset values immediately (before the next clk edge).
6. Concurrent load/transfer:
   - Stimulus: W_en, s_sig and R_en all high from the same cycle, loading 16 bytes.
   - Required: Weight_Memory matches the load order and done=1 within 20 cycles.
